// File: rtl/time_keeper_bcd.sv
// 24-hour hh:mm:ss time-of-day in packed BCD, advanced by rising edges of an asynchronous 1 Hz input.
// Includes a valid/ready load port with range checking.
module time_keeper_bcd #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       run,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_ready,
    output logic       set_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       day_tick
);

    typedef enum logic {
        ARM,
        LIVE
    } state_t;

    localparam int FILL_MAX = SYNC_STAGES + 1;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   s_q;
    logic                   s_prev;
    logic                   rise;
    logic                   tick;
    logic [FILL_W-1:0]      fill;
    state_t                 state;
    state_t                 state_next;
    logic                   in_range;
    logic                   load_ok;
    logic                   load_bad;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
            s_q        <= 1'b0;
            s_prev     <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], sec_in};
            s_q        <= sync_chain[SYNC_STAGES-1];
            s_prev     <= s_q;
        end
    end

    assign rise = s_q & ~s_prev;

    // s_q only reflects sec_in once the reset zeros have drained out of the pipeline,
    // so arming waits for that before trusting a low level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fill <= '0;
        else if (state == ARM && fill != FILL_W'(FILL_MAX))
            fill <= fill + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ARM;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        tick       = 1'b0;
        case (state)
            ARM: begin
                if (fill == FILL_W'(FILL_MAX) && !s_q)
                    state_next = LIVE;
            end
            LIVE: begin
                tick = rise & run;
            end
            default: state_next = ARM;
        endcase
    end

    assign set_ready = 1'b1;
    assign in_range  = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59) && bcd_ok(set_ss, 8'h59);
    assign load_ok   = set_valid & set_ready & in_range;
    assign load_bad  = set_valid & set_ready & ~in_range;

    // An accepted load overrides a coincident tick; a rejected one lets it through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            day_tick <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            day_tick <= 1'b0;
            set_err  <= load_bad;
            if (load_ok) begin
                hh <= set_hh;
                mm <= set_mm;
                ss <= set_ss;
            end else if (tick) begin
                sec_tick <= 1'b1;
                if (ss == 8'h59) begin
                    ss       <= 8'h00;
                    min_tick <= 1'b1;
                    if (mm == 8'h59) begin
                        mm <= 8'h00;
                        if (hh == 8'h23) begin
                            hh       <= 8'h00;
                            day_tick <= 1'b1;
                        end else begin
                            hh <= bcd_inc(hh);
                        end
                    end else begin
                        mm <= bcd_inc(mm);
                    end
                end else begin
                    ss <= bcd_inc(ss);
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Bench for time_keeper_bcd: a seconds-of-day model checked every cycle, plus directed
// literal expectations and a randomized stretch.
module tb_time_keeper_bcd;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_in = 1'b0;
    logic       run = 1'b1;
    logic       set_valid = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic       set_ready;
    logic       set_err;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_tick;
    logic       min_tick;
    logic       day_tick;

    int nCompared   = 0;
    int nMismatched = 0;

    int mTod   = 0;
    int mEdges = 0;
    bit mArmed = 1'b0;
    bit mSec = 1'b0, mMin = 1'b0, mDay = 1'b0, mErr = 1'b0;
    bit mSq, mSp, mTick, mOk;
    bit mHist[$];

    int phase = 0;
    int half  = 8;

    always #5 clk = ~clk;

    time_keeper_bcd #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_in    (sec_in),
        .run       (run),
        .set_valid (set_valid),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
        .set_ready (set_ready),
        .set_err   (set_err),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .sec_tick  (sec_tick),
        .min_tick  (min_tick),
        .day_tick  (day_tick)
    );

    function automatic int bcdVal(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit fieldOk(input logic [7:0] b, input int maxVal);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcdVal(b) <= maxVal);
    endfunction

    function automatic logic [7:0] toBcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic modelReset();
        mTod   = 0;
        mEdges = 0;
        mArmed = 1'b0;
        mSec   = 1'b0;
        mMin   = 1'b0;
        mDay   = 1'b0;
        mErr   = 1'b0;
        mHist.delete();
        repeat (SYNC + 2) mHist.push_back(1'b0);
    endtask

    task automatic modelAdvance();
        mTod = (mTod + 1) % 86400;
        mSec = 1'b1;
        mMin = (mTod % 60 == 0);
        mDay = (mTod == 0);
    endtask

    // Reference: mHist holds the last SYNC+2 sampled sec_in values, oldest first, so the
    // synchronised level seen at this edge is the sample SYNC+1 edges back.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            modelReset();
        end else begin
            mEdges++;
            mSq   = mHist[1];
            mSp   = mHist[0];
            mTick = mArmed && mSq && !mSp && (run == 1'b1);
            if (!mArmed && (mEdges - 1 >= SYNC + 1) && !mSq)
                mArmed = 1'b1;
            void'(mHist.pop_front());
            mHist.push_back(sec_in);
            mSec = 1'b0;
            mMin = 1'b0;
            mDay = 1'b0;
            mErr = 1'b0;
            if (set_valid) begin
                mOk = fieldOk(set_hh, 23) && fieldOk(set_mm, 59) && fieldOk(set_ss, 59);
                if (mOk) begin
                    mTod = bcdVal(set_hh) * 3600 + bcdVal(set_mm) * 60 + bcdVal(set_ss);
                end else begin
                    mErr = 1'b1;
                    if (mTick) modelAdvance();
                end
            end else if (mTick) begin
                modelAdvance();
            end
        end
    end

    task automatic checkValue(input string name, input logic [7:0] got, input logic [7:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("hh", hh, toBcd(mTod / 3600));
        checkValue("mm", mm, toBcd((mTod / 60) % 60));
        checkValue("ss", ss, toBcd(mTod % 60));
        checkValue("sec_tick", {7'd0, sec_tick}, {7'd0, mSec});
        checkValue("min_tick", {7'd0, min_tick}, {7'd0, mMin});
        checkValue("day_tick", {7'd0, day_tick}, {7'd0, mDay});
        checkValue("set_err", {7'd0, set_err}, {7'd0, mErr});
        checkValue("set_ready", {7'd0, set_ready}, 8'd1);
    endtask

    initial forever begin
        @(negedge clk);
        checkOutput();
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full sec_in period (8 high, 8 low) with the tick cycle checked at rise-sample + 3.
    task automatic secRise(input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                           input bit eSec, input bit eMin, input bit eDay);
        sec_in = 1'b1;
        repeat (4) @(negedge clk);
        checkValue("early_tick", {7'd0, sec_tick}, 8'd0);
        @(negedge clk);
        checkValue("rise_hh", hh, eh);
        checkValue("rise_mm", mm, em);
        checkValue("rise_ss", ss, es);
        checkValue("rise_sec", {7'd0, sec_tick}, {7'd0, eSec});
        checkValue("rise_min", {7'd0, min_tick}, {7'd0, eMin});
        checkValue("rise_day", {7'd0, day_tick}, {7'd0, eDay});
        @(negedge clk);
        checkValue("tick_width", {7'd0, sec_tick}, 8'd0);
        @(posedge clk);
        #1;
        waitCycles(2);
        sec_in = 1'b0;
        waitCycles(8);
    endtask

    task automatic secQuiet();
        sec_in = 1'b1;
        waitCycles(8);
        sec_in = 1'b0;
        waitCycles(8);
    endtask

    task automatic loadValid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_valid = 1'b1;
        set_hh    = h;
        set_mm    = m;
        set_ss    = s;
        waitCycles(1);
        set_valid = 1'b0;
    endtask

    task automatic loadAndCheck(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input bit eErr, input logic [7:0] eh, input logic [7:0] em,
                                input logic [7:0] es);
        set_valid = 1'b1;
        set_hh    = h;
        set_mm    = m;
        set_ss    = s;
        @(posedge clk);
        @(negedge clk);
        checkValue("load_err", {7'd0, set_err}, {7'd0, eErr});
        checkValue("load_hh", hh, eh);
        checkValue("load_mm", mm, em);
        checkValue("load_ss", ss, es);
        checkValue("load_pulses", {5'd0, sec_tick, min_tick, day_tick}, 8'd0);
        set_valid = 1'b0;
        @(posedge clk);
        #1;
        checkValue("err_width", {7'd0, set_err}, 8'd0);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            phase++;
            if (phase >= half) begin
                sec_in = ~sec_in;
                phase  = 0;
                if (sec_in == 1'b0) half = int'($urandom_range(3, 12));
            end
            if (set_valid && $urandom_range(0, 1) == 0) begin
                set_valid = 1'b0;
            end else if (!set_valid && $urandom_range(0, 15) == 0) begin
                set_valid = 1'b1;
                case ($urandom_range(0, 2))
                    0: begin
                        set_hh = 8'($urandom);
                        set_mm = 8'($urandom);
                        set_ss = 8'($urandom);
                    end
                    1: begin
                        set_hh = toBcd(int'($urandom_range(0, 23)));
                        set_mm = toBcd(int'($urandom_range(0, 59)));
                        set_ss = toBcd(int'($urandom_range(0, 59)));
                    end
                    default: begin
                        set_hh = 8'h23;
                        set_mm = 8'h59;
                        set_ss = toBcd(int'($urandom_range(50, 59)));
                    end
                endcase
            end
            if ($urandom_range(0, 63) == 0) run = ~run;
            waitCycles(1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        sec_in = 1'b1;
        run    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset released with sec_in high");
        waitCycles(20);
        checkValue("t1_ss", ss, 8'h00);

        $display("[TB] counting ten rises");
        sec_in = 1'b0;
        waitCycles(8);
        secRise(8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        repeat (9) secQuiet();
        waitCycles(4);
        checkValue("t2_ss", ss, 8'h10);

        $display("[TB] day wrap");
        loadValid(8'h23, 8'h59, 8'h58);
        checkValue("t3_load_hh", hh, 8'h23);
        checkValue("t3_load_ss", ss, 8'h58);
        secQuiet();
        checkValue("t3_ss59", ss, 8'h59);
        secRise(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);

        $display("[TB] load range checks");
        loadAndCheck(8'h24, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
        loadAndCheck(8'h12, 8'h5A, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
        loadAndCheck(8'h12, 8'h34, 8'h56, 1'b0, 8'h12, 8'h34, 8'h56);
        set_valid = 1'b1;
        secQuiet();
        checkValue("t4_frozen_ss", ss, 8'h56);
        set_valid = 1'b0;
        waitCycles(2);

        $display("[TB] load coinciding with tick, then run=0");
        sec_in = 1'b1;
        repeat (4) @(negedge clk);
        set_valid = 1'b1;
        set_hh    = 8'h01;
        set_mm    = 8'h02;
        set_ss    = 8'h03;
        @(negedge clk);
        checkValue("t5_hh", hh, 8'h01);
        checkValue("t5_mm", mm, 8'h02);
        checkValue("t5_ss", ss, 8'h03);
        checkValue("t5_no_tick", {7'd0, sec_tick}, 8'd0);
        set_valid = 1'b0;
        @(posedge clk);
        #1;
        waitCycles(2);
        sec_in = 1'b0;
        waitCycles(8);
        run = 1'b0;
        repeat (3) secQuiet();
        checkValue("t5_hold_ss", ss, 8'h03);
        sec_in = 1'b1;
        repeat (5) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        checkValue("t5_resume_tick", {7'd0, sec_tick}, 8'd0);
        @(posedge clk);
        #1;
        waitCycles(2);
        sec_in = 1'b0;
        waitCycles(8);
        checkValue("t5_resume_ss", ss, 8'h03);

        $display("[TB] randomized stretch");
        applyStimulus(3000);
        run       = 1'b1;
        set_valid = 1'b0;
        sec_in    = 1'b0;
        waitCycles(20);

        $display("[TB] asynchronous reset mid-count");
        loadValid(8'h07, 8'h15, 8'h30);
        checkValue("t6_load_mm", mm, 8'h15);
        sec_in = 1'b1;
        waitCycles(2);
        #2;
        rst = 1'b1;
        #1;
        checkValue("t6_rst_hh", hh, 8'h00);
        checkValue("t6_rst_mm", mm, 8'h00);
        checkValue("t6_rst_ss", ss, 8'h00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitCycles(20);
        checkValue("t6_arm_ss", ss, 8'h00);
        sec_in = 1'b0;
        waitCycles(8);
        secRise(8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
